spi_rx_sync: RTL and testbench
==============================

Name: spi_rx_sync

Overview:
- SPI slave receiver. Oversamples SCK/CSN/SDI in the system clock domain, so no SPI-clocked logic and no clock-domain handshake is needed.
- Generalises the SCK-clocked byte receiver:
  - parametrised word width;
  - all four SPI modes;
  - MSB/LSB-first ordering;
  - frame-aligned bit counting;
  - valid/ready output with overrun detection.
- Sits between the SPI pins and the Wishbone master's command parser.

Parameters:
- WIDTH, 8: bits per received word (2..32).
- CPOL, 0: SCK idle level (0 or 1).
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- LSB_FIRST, 0: 0 = first bit lands in data[WIDTH-1]; 1 = first bit lands in data[0].
- SYNC_STAGES, 2: synchroniser depth on each SPI input (2..3).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- spi_sck  in  1  SPI clock, asynchronous to clk.
- spi_csn  in  1  chip select, active low, asynchronous.
- spi_sdi  in  1  serial data in (MOSI), asynchronous.
- data_valid  out  1  received word available.
- data_ready  in  1  consumer accepts word.
- data  out  WIDTH  received word.
- frame_first  out  1  qualifies data: word is the first since CSN fell.
- overrun  out  1  one-cycle pulse: a complete word was dropped.

Behaviour:
- Clocking and reset
  - Single clock domain clk; reset is synchronous, active high.
  - Reset values: data_valid=0, data=0, frame_first=0, overrun=0; bit counter=0; shift register=0; FSM=IDLE.
  - Synchroniser flops reset to idle levels: sck=CPOL, csn=1, sdi=0.
- Input conditioning
  - Each SPI input passes through SYNC_STAGES flops, plus one history flop on sck for edge detection.
  - Sample edge = rising when CPOL==CPHA, falling otherwise. The other SCK edge is ignored.
  - Requirement: f_clk >= 4 * f_sck. Behaviour above that rate is undefined.
- FSM states
  - IDLE: synchronised csn=1. Shift register and bit counter are held at 0.
  - SHIFT: synchronised csn=0.
  - IDLE -> SHIFT when synchronised csn falls. Sets a first_pending flag.
  - SHIFT -> IDLE when synchronised csn rises. Any partial word is discarded silently, with no overrun. Counter clears.
- Shifting (SHIFT state)
  - On each detected sample edge, capture synchronised sdi.
  - LSB_FIRST=0: shift left, inserting at bit 0.
  - LSB_FIRST=1: shift right, inserting at bit WIDTH-1.
  - Counter increments modulo WIDTH.
  - The sample edge that brings the counter to WIDTH-1->0 completes a word; the next word begins immediately (back-to-back words, no gap).
- Output stage
  - Single-entry holding register with valid/ready semantics.
  - A transfer occurs on a cycle where data_valid && data_ready.
  - While data_valid=1, data and frame_first are stable until transferred.
  - Completed word is loaded in the cycle after the completing edge is detected.
  - Latency from pin edge to data_valid: SYNC_STAGES+2 clk, ±1 for synchroniser metastability resolution.
- Load rules when a word completes
  - Slot empty, or transfer in the same cycle: load word; data_valid=1; frame_first=first_pending; clear first_pending.
  - Slot full and no transfer: drop the new word; pulse overrun for 1 cycle; the held word is kept. first_pending is still cleared.
- Other boundaries
  - data_ready is don't-care while data_valid=0.
  - CSN rising while a word is held does not affect the held word.
  - Reset mid-frame discards everything. After reset the block waits for the next CSN fall, so no partial-word realignment occurs.
  - A glitch on CSN shorter than SYNC_STAGES clk may be missed.

Decomposition:
- Shared package spi_pkg:
  - SPI mode encoding constants (MODE0..MODE3 -> CPOL/CPHA);
  - the derived sample-edge-select function;
  - counter width as $clog2(WIDTH).
- Sub-module: sync_edge, an N-stage synchroniser with rise/fall pulse outputs.
  - Instantiated three times (edges unused for sdi).

Test Plan:
- Mode 0, WIDTH=8, MSB first; CSN low; send 0xA5, then 0x3C back-to-back; data_ready=1 -> data=0xA5 with frame_first=1, then 0x3C with frame_first=0; overrun never asserted.
- Mode 3 (CPOL=1, CPHA=1), LSB_FIRST=1, WIDTH=16; send bit stream for 0x1234 LSB first -> data=0x1234, data_valid stays high until data_ready is asserted 10 cycles later.
- Backpressure: data_ready=0; send 0x11, 0x22, 0x33 -> data holds 0x11; overrun pulses exactly twice, 1 cycle each; after data_ready=1, one transfer of 0x11, then data_valid=0.
- Partial frame: send 5 bits of 0xFF, raise CSN, lower CSN, send 0x81 -> only 0x81 delivered with frame_first=1; no overrun.
- Reset mid-word: assert rst for 1 cycle after 3 bits -> all outputs 0 next cycle; following frame 0x5A is received correctly.
- Simultaneous complete and drain: hold data_valid=1 with 0x01, assert data_ready in exactly the cycle 0x02 completes -> 0x01 transferred, 0x02 loaded the same cycle, no overrun.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the oversampled SPI receiver: mode encoding,
// sample-edge selection and counter sizing.
package spi_pkg;

  // Mode encoding is {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  function automatic logic [1:0] spi_mode(input int cpol, input int cpha);
    if (cpol == 0 && cpha == 0) return MODE0;
    else if (cpol == 0)         return MODE1;
    else if (cpha == 0)         return MODE2;
    else                        return MODE3;
  endfunction

  // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling edge
  function automatic logic sample_on_rise(input logic [1:0] mode);
    return (mode == MODE0) || (mode == MODE3);
  endfunction

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// N-stage synchroniser for one asynchronous input, with a history flop that
// produces single-cycle rise/fall pulses on the synchronised level.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_rx_sync.sv
// SPI slave receiver oversampled in the clk domain: frame-aligned shifting,
// any SPI mode, MSB/LSB-first, single-entry valid/ready output with overrun.
module spi_rx_sync
  import spi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int LSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_sck,
  input  logic             spi_csn,
  input  logic             spi_sdi,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data,
  output logic             frame_first,
  output logic             overrun
);

  localparam int            CW          = cnt_width(WIDTH);
  localparam logic          SAMPLE_RISE = sample_on_rise(spi_mode(CPOL, CPHA));
  localparam logic [CW-1:0] LAST        = CW'(WIDTH - 1);

  logic sck_level_unused, sck_rise, sck_fall;
  logic csn_level_unused, csn_rise, csn_fall;
  logic sdi_level, sdi_rise_unused, sdi_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL != 0)) u_sck (
    .clk(clk), .rst(rst), .async_in(spi_sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_csn (
    .clk(clk), .rst(rst), .async_in(spi_csn),
    .level(csn_level_unused), .rise(csn_rise), .fall(csn_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sdi (
    .clk(clk), .rst(rst), .async_in(spi_sdi),
    .level(sdi_level), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
  );

  rx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_next, word_q;
  logic [CW-1:0]    cnt_q;
  logic             sample, word_done_q, first_pending;

  assign sample = SAMPLE_RISE ? sck_rise : sck_fall;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (csn_fall) state_d = SHIFT;
      SHIFT:   if (csn_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_next = shift_q;
    if (LSB_FIRST != 0) shift_next = {sdi_level, shift_q[WIDTH-1:1]};
    else                shift_next = {shift_q[WIDTH-2:0], sdi_level};
  end

  // Completed words are staged one cycle before reaching the output slot
  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE || csn_rise) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      word_done_q <= 1'b0;
      word_q      <= rst ? '0 : word_q;
    end else begin
      word_done_q <= 1'b0;
      if (sample) begin
        shift_q <= shift_next;
        cnt_q   <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          word_done_q <= 1'b1;
          word_q      <= shift_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_pending <= 1'b0;
    end else if (state_q == IDLE && csn_fall) begin
      first_pending <= 1'b1;
    end else if (word_done_q) begin
      first_pending <= 1'b0;
    end
  end

  // A new word may replace the held one only in the cycle it is transferred
  always_ff @(posedge clk) begin
    if (rst) begin
      data_valid  <= 1'b0;
      data        <= '0;
      frame_first <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (word_done_q) begin
        if (!data_valid || data_ready) begin
          data_valid  <= 1'b1;
          data        <= word_q;
          frame_first <= first_pending;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_rx_sync.sv
// Scoreboard bench for spi_rx_sync: a mode-0 byte receiver and a mode-3
// LSB-first 16-bit receiver driven from bit-level SPI tasks.
module tb_spi_rx_sync;

  typedef struct {
    logic [31:0] data;
    logic        first;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        sck_a = 1'b0, csn_a = 1'b1, sdi_a = 1'b0, ready_a = 1'b0;
  logic        valid_a, ff_a, ov_a;
  logic [7:0]  data_a;
  logic        sck_b = 1'b1, csn_b = 1'b1, sdi_b = 1'b0, ready_b = 1'b0;
  logic        valid_b, ff_b, ov_b;
  logic [15:0] data_b;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t mon_a_e, mon_b_e;

  int errors = 0;
  int checks = 0;
  int ov_cnt_a = 0, ov_cnt_b = 0, ov_wide = 0;
  logic ov_prev_a = 1'b0, ov_prev_b = 1'b0;
  int ov_base;

  always #5 clk = ~clk;

  spi_rx_sync #(.WIDTH(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .spi_sck(sck_a), .spi_csn(csn_a), .spi_sdi(sdi_a),
    .data_valid(valid_a), .data_ready(ready_a), .data(data_a),
    .frame_first(ff_a), .overrun(ov_a)
  );

  spi_rx_sync #(.WIDTH(16), .CPOL(1), .CPHA(1), .LSB_FIRST(1), .SYNC_STAGES(3)) dut_b (
    .clk(clk), .rst(rst), .spi_sck(sck_b), .spi_csn(csn_b), .spi_sdi(sdi_b),
    .data_valid(valid_b), .data_ready(ready_b), .data(data_b),
    .frame_first(ff_b), .overrun(ov_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spi_bit_a(input logic b);
    sdi_a = b;
    cycles(4);
    sck_a = 1'b1;
    cycles(4);
    sck_a = 1'b0;
  endtask

  task automatic spi_bit_b(input logic b);
    sck_b = 1'b0;
    sdi_b = b;
    cycles(4);
    sck_b = 1'b1;
    cycles(4);
  endtask

  task automatic send_bits_a(input logic [7:0] w, input int n);
    for (int i = 7; i > 7 - n; i--) spi_bit_a(w[i]);
  endtask

  // Sends one full word to the mode-0 receiver, optionally expecting it delivered
  task automatic applyStimulus(input logic [7:0] w, input logic expect_it, input logic first);
    exp_t e;
    if (expect_it) begin
      e.data  = {24'd0, w};
      e.first = first;
      sb_a.push_back(e);
    end
    send_bits_a(w, 8);
  endtask

  task automatic applyStimulusB(input logic [15:0] w, input logic first);
    exp_t e;
    e.data  = {16'd0, w};
    e.first = first;
    sb_b.push_back(e);
    for (int i = 0; i < 16; i++) spi_bit_b(w[i]);
  endtask

  task automatic wait_valid_a(input int limit);
    int k = 0;
    while (!valid_a && k < limit) begin
      cycles(1);
      k++;
    end
    if (!valid_a) checkOutput("a_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid_b(input int limit);
    int k = 0;
    while (!valid_b && k < limit) begin
      cycles(1);
      k++;
    end
    if (!valid_b) checkOutput("b_valid_timeout", 32'd0, 32'd1);
  endtask

  // Transfers are observed mid-cycle, before the edge that completes them
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_a && ready_a) begin
        if (sb_a.size() == 0) checkOutput("a_unexpected_word", {24'd0, data_a}, 32'hFFFF_FFFF);
        else begin
          mon_a_e = sb_a.pop_front();
          checkOutput("a_data", {24'd0, data_a}, mon_a_e.data);
          checkOutput("a_first", {31'd0, ff_a}, {31'd0, mon_a_e.first});
        end
      end
      if (valid_b && ready_b) begin
        if (sb_b.size() == 0) checkOutput("b_unexpected_word", {16'd0, data_b}, 32'hFFFF_FFFF);
        else begin
          mon_b_e = sb_b.pop_front();
          checkOutput("b_data", {16'd0, data_b}, mon_b_e.data);
          checkOutput("b_first", {31'd0, ff_b}, {31'd0, mon_b_e.first});
        end
      end
      if (ov_a) begin
        ov_cnt_a++;
        if (ov_prev_a) ov_wide++;
      end
      if (ov_b) begin
        ov_cnt_b++;
        if (ov_prev_b) ov_wide++;
      end
    end
    ov_prev_a = ov_a;
    ov_prev_b = ov_b;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    cycles(3);
    rst = 1'b0;
    checkOutput("rst_a_valid", {31'd0, valid_a}, 32'd0);
    checkOutput("rst_a_data", {24'd0, data_a}, 32'd0);
    checkOutput("rst_a_first", {31'd0, ff_a}, 32'd0);
    checkOutput("rst_a_overrun", {31'd0, ov_a}, 32'd0);
    checkOutput("rst_b_valid", {31'd0, valid_b}, 32'd0);
    checkOutput("rst_b_data", {16'd0, data_b}, 32'd0);
    checkOutput("rst_b_first", {31'd0, ff_b}, 32'd0);
    checkOutput("rst_b_overrun", {31'd0, ov_b}, 32'd0);

    $display("[TB] mode 0 back-to-back words");
    ov_base = ov_cnt_a;
    ready_a = 1'b1;
    csn_a = 1'b0;
    cycles(4);
    applyStimulus(8'hA5, 1'b1, 1'b1);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    cycles(10);
    csn_a = 1'b1;
    cycles(8);
    checkOutput("basic_overrun", ov_cnt_a - ov_base, 32'd0);
    checkOutput("basic_drained", sb_a.size(), 32'd0);

    $display("[TB] mode 3 LSB-first 16-bit word with delayed ready");
    csn_b = 1'b0;
    cycles(4);
    applyStimulusB(16'h1234, 1'b1);
    wait_valid_b(40);
    cycles(10);
    checkOutput("b_hold_valid", {31'd0, valid_b}, 32'd1);
    checkOutput("b_hold_data", {16'd0, data_b}, 32'h1234);
    ready_b = 1'b1;
    cycles(2);
    checkOutput("b_after_valid", {31'd0, valid_b}, 32'd0);
    ready_b = 1'b0;
    csn_b = 1'b1;
    cycles(8);

    $display("[TB] backpressure with two dropped words");
    ov_base = ov_cnt_a;
    ready_a = 1'b0;
    csn_a = 1'b0;
    cycles(4);
    applyStimulus(8'h11, 1'b0, 1'b1);
    applyStimulus(8'h22, 1'b0, 1'b0);
    applyStimulus(8'h33, 1'b0, 1'b0);
    cycles(10);
    checkOutput("bp_data", {24'd0, data_a}, 32'h11);
    checkOutput("bp_first", {31'd0, ff_a}, 32'd1);
    checkOutput("bp_overruns", ov_cnt_a - ov_base, 32'd2);
    mon_a_e.data = 32'h11;
    mon_a_e.first = 1'b1;
    sb_a.push_back(mon_a_e);
    ready_a = 1'b1;
    cycles(3);
    checkOutput("bp_after_valid", {31'd0, valid_a}, 32'd0);
    csn_a = 1'b1;
    cycles(8);

    $display("[TB] partial frame then fresh frame");
    ov_base = ov_cnt_a;
    csn_a = 1'b0;
    cycles(4);
    send_bits_a(8'hFF, 5);
    cycles(4);
    csn_a = 1'b1;
    cycles(8);
    csn_a = 1'b0;
    cycles(4);
    applyStimulus(8'h81, 1'b1, 1'b1);
    cycles(10);
    csn_a = 1'b1;
    cycles(8);
    checkOutput("partial_overrun", ov_cnt_a - ov_base, 32'd0);
    checkOutput("partial_drained", sb_a.size(), 32'd0);

    $display("[TB] word completes in the cycle the held word drains");
    ov_base = ov_cnt_a;
    ready_a = 1'b0;
    csn_a = 1'b0;
    cycles(4);
    applyStimulus(8'h01, 1'b1, 1'b1);
    wait_valid_a(40);
    mon_a_e.data = 32'h02;
    mon_a_e.first = 1'b0;
    sb_a.push_back(mon_a_e);
    send_bits_a(8'h02, 7);
    sdi_a = 1'b0;
    cycles(4);
    sck_a = 1'b1;
    cycles(3);
    ready_a = 1'b1;
    cycles(1);
    ready_a = 1'b0;
    checkOutput("sim_valid", {31'd0, valid_a}, 32'd1);
    checkOutput("sim_data", {24'd0, data_a}, 32'h02);
    checkOutput("sim_first", {31'd0, ff_a}, 32'd0);
    cycles(3);
    sck_a = 1'b0;
    cycles(4);
    checkOutput("sim_overrun", ov_cnt_a - ov_base, 32'd0);
    ready_a = 1'b1;
    cycles(3);
    ready_a = 1'b0;
    csn_a = 1'b1;
    cycles(8);
    checkOutput("sim_drained", sb_a.size(), 32'd0);

    $display("[TB] reset mid-word");
    csn_a = 1'b0;
    cycles(4);
    applyStimulus(8'h77, 1'b0, 1'b1);
    wait_valid_a(40);
    send_bits_a(8'hE0, 3);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    checkOutput("mid_rst_valid", {31'd0, valid_a}, 32'd0);
    checkOutput("mid_rst_data", {24'd0, data_a}, 32'd0);
    checkOutput("mid_rst_first", {31'd0, ff_a}, 32'd0);
    checkOutput("mid_rst_overrun", {31'd0, ov_a}, 32'd0);
    csn_a = 1'b1;
    cycles(8);
    csn_a = 1'b0;
    cycles(4);
    ready_a = 1'b1;
    applyStimulus(8'h5A, 1'b1, 1'b1);
    cycles(10);
    csn_a = 1'b1;
    cycles(8);

    checkOutput("final_sb_a", sb_a.size(), 32'd0);
    checkOutput("final_sb_b", sb_b.size(), 32'd0);
    checkOutput("overrun_width", ov_wide, 32'd0);
    checkOutput("b_overruns", ov_cnt_b, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
